// File: rtl/bram_pkg.sv
// bram_pkg: write-mode encoding, collision counter width and the byte-lane merge helper
// shared by bram_tdp_be_pipe and its output stage.
package bram_pkg;
  typedef enum logic [1:0] {RD_FIRST, WR_FIRST, NO_CHANGE} wmode_e;
  localparam int COLL_CNT_W = 16;
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic we);
    return we ? new_b : old_b;
  endfunction
endpackage

// File: rtl/bram_port_out.sv
// bram_port_out: per-port read-data select by write mode, read register with valid strobe,
// and an optional second output register that loads only on valid.
module bram_port_out
  import bram_pkg::*;
#(
  parameter int     WIDTH   = 256,
  parameter wmode_e WMODE   = RD_FIRST,
  parameter int     OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] new_word,
  output logic [WIDTH-1:0] dout,
  output logic             vld
);
  logic [WIDTH-1:0] rd_d, rd_q;
  logic             v_d, v_q;
  always_comb begin
    v_d  = en & ~(wr & (WMODE == NO_CHANGE));
    rd_d = v_d ? ((WMODE == WR_FIRST) ? new_word : old_word) : rd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      v_q  <= 1'b0;
    end else begin
      rd_q <= rd_d;
      v_q  <= v_d;
    end
  end
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] do_d, do_q;
      logic             vo_d, vo_q;
      always_comb begin
        vo_d = v_q;
        do_d = v_q ? rd_q : do_q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          do_q <= '0;
          vo_q <= 1'b0;
        end else begin
          do_q <= do_d;
          vo_q <= vo_d;
        end
      end
      assign dout = do_q;
      assign vld  = vo_q;
    end else begin : g_noreg
      assign dout = rd_q;
      assign vld  = v_q;
    end
  endgenerate
endmodule

// File: rtl/bram_tdp_be_pipe.sv
// bram_tdp_be_pipe: single-clock true-dual-port RAM with byte enables, per-port write modes and
// optional output register. Define BRAM_TDP_COLL_CNT_EN to add the coll/coll_cnt collision monitor.
module bram_tdp_be_pipe
  import bram_pkg::*;
#(
  parameter int     SIZE    = 1024,
  parameter int     WIDTH   = 256,
  parameter wmode_e WMODE_A = RD_FIRST,
  parameter wmode_e WMODE_B = RD_FIRST,
  parameter int     OUT_REG = 0,
  localparam int    AW      = $clog2(SIZE),
  localparam int    NB      = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             enb,
  input  logic [NB-1:0]    wea,
  input  logic [NB-1:0]    web,
  input  logic [AW-1:0]    addra,
  input  logic [AW-1:0]    addrb,
  input  logic [WIDTH-1:0] dia,
  input  logic [WIDTH-1:0] dib,
  output logic [WIDTH-1:0] doa,
  output logic [WIDTH-1:0] dob,
  output logic             vlda,
  output logic             vldb
`ifdef BRAM_TDP_COLL_CNT_EN
  ,
  output logic             coll,
  output logic [COLL_CNT_W-1:0] coll_cnt
`endif
);
  logic [WIDTH-1:0] ram [SIZE];
  logic [WIDTH-1:0] old_a, old_b, mrg_a, mrg_b;
  logic             wr_a, wr_b;
  always_comb begin
    old_a = ram[addra];
    old_b = ram[addrb];
    wr_a  = |wea;
    wr_b  = |web;
    mrg_a = old_a;
    mrg_b = old_b;
    for (int i = 0; i < NB; i++) begin
      mrg_a[i*8+:8] = byte_merge(old_a[i*8+:8], dia[i*8+:8], wea[i]);
      mrg_b[i*8+:8] = byte_merge(old_b[i*8+:8], dib[i*8+:8], web[i]);
    end
  end
  // Port A is written last so it wins lanes both ports enable on a shared address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (enb && web[i]) ram[addrb][i*8+:8] <= dib[i*8+:8];
      if (ena && wea[i]) ram[addra][i*8+:8] <= dia[i*8+:8];
    end
  end
  bram_port_out #(.WIDTH(WIDTH), .WMODE(WMODE_A), .OUT_REG(OUT_REG)) u_out_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ena),
    .wr       (wr_a),
    .old_word (old_a),
    .new_word (mrg_a),
    .dout     (doa),
    .vld      (vlda)
  );
  bram_port_out #(.WIDTH(WIDTH), .WMODE(WMODE_B), .OUT_REG(OUT_REG)) u_out_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (enb),
    .wr       (wr_b),
    .old_word (old_b),
    .new_word (mrg_b),
    .dout     (dob),
    .vld      (vldb)
  );
`ifdef BRAM_TDP_COLL_CNT_EN
  logic                  coll_d, coll_q;
  logic [COLL_CNT_W-1:0] coll_cnt_d, coll_cnt_q;
  always_comb begin
    coll_d     = ena & enb & (addra == addrb) & (wr_a | wr_b);
    coll_cnt_d = (coll_d && coll_cnt_q != '1) ? coll_cnt_q + COLL_CNT_W'(1) : coll_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_q     <= coll_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end
  assign coll     = coll_q;
  assign coll_cnt = coll_cnt_q;
`endif
endmodule

// File: tb/tb_bram_tdp_be_pipe.sv
// tb_bram_tdp_be_pipe: two instances (RD_FIRST/RD_FIRST unregistered, WR_FIRST/NO_CHANGE registered)
// driven in lockstep and checked every cycle against a word-level memory model.
module tb_bram_tdp_be_pipe;
  import bram_pkg::*;
  localparam int W = 32, NB = 4, SZ = 16, AW = 4;
  typedef struct packed {logic v; logic k; logic [W-1:0] d;} res_t;
  localparam res_t RZ = {1'b0, 1'b1, {W{1'b0}}};
  logic clk = 1'b0, rst_n = 1'b1;
  logic ena, enb;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [W-1:0] dia, dib, doa0, dob0, doa1, dob1, saved;
  logic vlda0, vldb0, vlda1, vldb1;
  logic [W-1:0] mem [SZ];
  logic known [SZ];
  res_t x0a, x0b, x1a, x1b, q1a, q1b;
  logic ecoll;
  logic [15:0] ecnt;
  int n_pass = 0, n_chk = 0;
  always #5 clk = ~clk;
`ifdef BRAM_TDP_COLL_CNT_EN
  logic coll0, coll1;
  logic [COLL_CNT_W-1:0] cnt0, cnt1;
`endif
  bram_tdp_be_pipe #(.SIZE(SZ), .WIDTH(W), .WMODE_A(RD_FIRST), .WMODE_B(RD_FIRST), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dia(dia), .dib(dib), .doa(doa0), .dob(dob0), .vlda(vlda0), .vldb(vldb0)
`ifdef BRAM_TDP_COLL_CNT_EN
    , .coll(coll0), .coll_cnt(cnt0)
`endif
  );
  bram_tdp_be_pipe #(.SIZE(SZ), .WIDTH(W), .WMODE_A(WR_FIRST), .WMODE_B(NO_CHANGE), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dia(dia), .dib(dib), .doa(doa1), .dob(dob1), .vlda(vlda1), .vldb(vldb1)
`ifdef BRAM_TDP_COLL_CNT_EN
    , .coll(coll1), .coll_cnt(cnt1)
`endif
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic chk_res(input string tag, input logic [W-1:0] d, input logic v, input res_t x);
    chk({tag, "_vld"}, {31'b0, v}, {31'b0, x.v});
    if (x.k) chk({tag, "_do"}, d, x.d);
  endtask
  function automatic res_t port_res(input wmode_e m, input logic en, input logic [NB-1:0] we,
                                    input logic [AW-1:0] a, input logic [W-1:0] di);
    res_t r;
    r.v = en && !(m == NO_CHANGE && we != 0);
    r.k = known[a] || (m == WR_FIRST && we == '1);
    r.d = mem[a];
    if (m == WR_FIRST)
      for (int i = 0; i < NB; i++) if (we[i]) r.d[8*i+:8] = di[8*i+:8];
    return r;
  endfunction
  function automatic res_t nxt(input res_t x, input res_t r);
    return r.v ? r : {1'b0, x.k, x.d};
  endfunction
  task automatic model_reset();
    x0a = RZ; x0b = RZ; x1a = RZ; x1b = RZ; q1a = RZ; q1b = RZ;
    ecoll = 1'b0; ecnt = '0;
  endtask
  task automatic chk_zero();
    chk("rst_doa0", doa0, '0); chk("rst_vlda0", {31'b0, vlda0}, '0);
    chk("rst_dob0", dob0, '0); chk("rst_vldb0", {31'b0, vldb0}, '0);
    chk("rst_doa1", doa1, '0); chk("rst_vlda1", {31'b0, vlda1}, '0);
    chk("rst_dob1", dob1, '0); chk("rst_vldb1", {31'b0, vldb1}, '0);
  endtask
  task automatic cyc();
    res_t r0a, r0b, r1a, r1b;
    logic ce;
    r0a = port_res(RD_FIRST, ena, wea, addra, dia);
    r0b = port_res(RD_FIRST, enb, web, addrb, dib);
    r1a = port_res(WR_FIRST, ena, wea, addra, dia);
    r1b = port_res(NO_CHANGE, enb, web, addrb, dib);
    ce = ena && enb && addra == addrb && (wea != 0 || web != 0);
    @(posedge clk);
    for (int i = 0; i < NB; i++) begin
      if (enb && web[i]) mem[addrb][8*i+:8] = dib[8*i+:8];
      if (ena && wea[i]) mem[addra][8*i+:8] = dia[8*i+:8];
    end
    if (enb && web == '1) known[addrb] = 1'b1;
    if (ena && wea == '1) known[addra] = 1'b1;
    #1;
    if (!rst_n) model_reset();
    else begin
      x0a = nxt(x0a, r0a); x0b = nxt(x0b, r0b);
      x1a = nxt(x1a, q1a); x1b = nxt(x1b, q1b);
      q1a = r1a; q1b = r1b;
      ecoll = ce;
      if (ce && ecnt != 16'hFFFF) ecnt++;
    end
    chk_res("p0a", doa0, vlda0, x0a); chk_res("p0b", dob0, vldb0, x0b);
    chk_res("p1a", doa1, vlda1, x1a); chk_res("p1b", dob1, vldb1, x1b);
`ifdef BRAM_TDP_COLL_CNT_EN
    chk("coll0", {31'b0, coll0}, {31'b0, ecoll}); chk("coll1", {31'b0, coll1}, {31'b0, ecoll});
    chk("cnt0", {16'b0, cnt0}, {16'b0, ecnt}); chk("cnt1", {16'b0, cnt1}, {16'b0, ecnt});
`endif
  endtask
  initial begin
    ena = 0; enb = 0; wea = 0; web = 0; addra = 0; addrb = 0; dia = 0; dib = 0;
    for (int i = 0; i < SZ; i++) begin mem[i] = '0; known[i] = 1'b0; end
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_zero();
    cyc(); cyc();
    rst_n = 1'b1;
    ena = 1; wea = '1;
    for (int a = 0; a < SZ; a++) begin addra = AW'(a); dia = $urandom; cyc(); end
    // write A then read B at the same address on the next cycle
    addra = 5; dia = 32'hAAAA_AAAA; cyc();
    ena = 0; wea = 0; enb = 1; addrb = 5; cyc();
    chk("t1_dob", dob0, 32'hAAAA_AAAA); chk("t1_vldb", {31'b0, vldb0}, 32'd1);
    enb = 0;
    // byte-lane merge returned by the write-first port
    ena = 1; wea = '1; addra = 3; dia = 32'h1111_1111; cyc();
    wea = 4'h1; dia = 32'h0000_00FF; cyc();
    wea = 0; cyc();
    chk("t2_doa1_wr", doa1, 32'h1111_11FF); chk("t2_doa0_rd", doa0, 32'h1111_11FF);
    ena = 0; cyc();
    chk("t2_doa1_rd", doa1, 32'h1111_11FF); chk("t2_vlda1", {31'b0, vlda1}, 32'd1);
    // no-change port holds across its own write
    saved = mem[7];
    enb = 1; addrb = 7; cyc();
    web = '1; dib = ~saved; cyc();
    enb = 0; web = 0; cyc();
    chk("t3_dob1", dob1, saved); chk("t3_vldb1", {31'b0, vldb1}, 32'd0);
    // simultaneous full writes: port A wins
    ena = 1; enb = 1; wea = '1; web = '1; addra = 9; addrb = 9; dia = 32'h1111_1111; dib = 32'h2222_2222; cyc();
    enb = 0; web = 0; wea = 0; cyc();
    chk("t4_doa0", doa0, 32'h1111_1111);
    ena = 0; cyc();
    // registered burst interrupted by reset
    ena = 1;
    addra = 0; cyc(); chk("t5_v1_first", {31'b0, vlda1}, 32'd0);
    addra = 1; cyc(); chk("t5_v1_second", {31'b0, vlda1}, 32'd1);
    addra = 2; cyc();
    ena = 0;
    #2 rst_n = 1'b0;
    #1 chk_zero();
    model_reset();
    cyc();
    rst_n = 1'b1;
    ena = 1;
    for (int a = 0; a < 4; a++) begin addra = AW'(a); cyc(); end
    ena = 0; cyc();
    for (int n = 0; n < 400; n++) begin
      ena = 1'($urandom); enb = 1'($urandom);
      wea = $urandom_range(0, 1) ? NB'($urandom) : '0;
      web = $urandom_range(0, 1) ? NB'($urandom) : '0;
      addra = AW'($urandom_range(0, 3)); addrb = AW'($urandom_range(0, 3));
      dia = $urandom; dib = $urandom;
      cyc();
    end
    ena = 0; enb = 0; wea = 0; web = 0;
    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
